// File: rtl/interrupt_capture_unit.sv
// Per-channel edge/level interrupt capture with sticky pending bits and lowest-index-first valid/ack presentation.
// Latency: pending at k+1, irq_valid at k+2 (k+3/k+4 with INTR_SYNC_EN); irq_id is held until ack, clear or disable.
module interrupt_capture_unit #(
    parameter int N_INTERRUPTS = 32,
    parameter int ID_W         = $clog2(N_INTERRUPTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_INTERRUPTS-1:0] irq_in,
    input  logic [N_INTERRUPTS-1:0] edge_mode,
    input  logic [N_INTERRUPTS-1:0] polarity,
    input  logic [N_INTERRUPTS-1:0] irq_enable,
    input  logic [N_INTERRUPTS-1:0] irq_clear,
    input  logic                    irq_ack,
    output logic [N_INTERRUPTS-1:0] pending,
    output logic                    irq_valid,
    output logic [ID_W-1:0]         irq_id
);

    logic [N_INTERRUPTS-1:0] w_det_in;
    logic [N_INTERRUPTS-1:0] r_prev;
    logic [N_INTERRUPTS-1:0] r_pending;
    logic [N_INTERRUPTS-1:0] w_edge;
    logic [N_INTERRUPTS-1:0] w_lvl;
    logic [N_INTERRUPTS-1:0] w_evt;
    logic [N_INTERRUPTS-1:0] w_cand;
    logic [N_INTERRUPTS-1:0] w_id_oh;
    logic [N_INTERRUPTS-1:0] w_pending_nxt;
    logic                    w_armed;
    logic                    r_valid;
    logic [ID_W-1:0]         r_irq_id;
    logic [ID_W-1:0]         w_low_id;
    logic                    w_any;
    logic                    w_ack_fire;
    logic                    w_drop;

`ifdef INTR_SYNC_EN
    // Arming waits for the synchronizer to hold real input values, not reset zeros.
    logic [N_INTERRUPTS-1:0] r_sync1;
    logic [N_INTERRUPTS-1:0] r_sync2;
    logic [1:0]              r_arm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_arm_cnt <= 2'd0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
            if (r_arm_cnt != 2'd3) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end
        end
    end

    assign w_det_in = r_sync2;
    assign w_armed  = (r_arm_cnt == 2'd3);
`else
    logic r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    assign w_det_in = irq_in;
    assign w_armed  = r_armed;
`endif

    assign w_edge = (w_det_in & ~r_prev & polarity) | (~w_det_in & r_prev & ~polarity);
    assign w_lvl  = ~(w_det_in ^ polarity);
    assign w_evt  = w_armed ? (((edge_mode & w_edge) | (~edge_mode & w_lvl)) & irq_enable)
                            : '0;

    assign w_ack_fire = r_valid & irq_ack;
    assign w_cand     = r_pending & irq_enable;

    always_comb begin
        w_low_id = '0;
        w_any    = 1'b0;
        for (int i = N_INTERRUPTS - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_low_id = ID_W'(i);
                w_any    = 1'b1;
            end
        end
    end

    always_comb begin
        w_id_oh = '0;
        for (int i = 0; i < N_INTERRUPTS; i++) begin
            w_id_oh[i] = (r_irq_id == ID_W'(i));
        end
    end

    // A new event outranks clear/ack so an edge landing in the same cycle is kept.
    assign w_pending_nxt = w_evt
                         | (r_pending & ~(irq_clear | (w_id_oh & {N_INTERRUPTS{w_ack_fire}})));

    assign w_drop = |(w_id_oh & ((irq_clear & ~w_evt) | ~irq_enable));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            r_prev    <= w_det_in;
            r_pending <= w_pending_nxt;
            if (r_valid) begin
                if (w_ack_fire || w_drop) begin
                    r_valid <= 1'b0;
                end
            end else begin
                r_valid <= w_any;
                if (w_any) begin
                    r_irq_id <= w_low_id;
                end
            end
        end
    end

    assign pending   = r_pending;
    assign irq_valid = r_valid;
    assign irq_id    = r_irq_id;

endmodule

// File: doc/interrupt_capture_unit.md
Name: interrupt_capture_unit

Overview:
- Parametrised successor to the external interrupt edge detector.
- Per channel, selectable edge/level detection and polarity; sticky pending bits with enable mask and software clear.
- Registered lowest-index-first arbitration, presenting one interrupt ID to the interrupt controller with a valid/ack handshake.

Parameters:
N_INTERRUPTS, 32, number of interrupt channels (2..64)
ID_W, $clog2(N_INTERRUPTS), width of irq_id (derived, do not override)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
irq_in  input  N_INTERRUPTS  raw external interrupt requests
edge_mode  input  N_INTERRUPTS  1 = edge-triggered, 0 = level-sensitive (quasi-static)
polarity  input  N_INTERRUPTS  1 = rising/high active, 0 = falling/low active (quasi-static)
irq_enable  input  N_INTERRUPTS  per-channel enable mask
irq_clear  input  N_INTERRUPTS  one-cycle pulse per bit, clears pending
irq_ack  input  1  consumer accepts the presented ID
pending  output  N_INTERRUPTS  registered pending bits
irq_valid  output  1  registered; an ID is presented
irq_id  output  ID_W  registered index of the presented channel

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state updates on posedge clk only.
- Reset: pending=0, irq_valid=0, irq_id=0, prev=0, armed=0.
- prev register: samples the detection input every cycle. armed is set 1 cycle after reset release. While armed=0, no events are generated, which avoids spurious edges from inputs already high at reset.
- Event per channel i, valid only when armed:
  - Edge, polarity=1: in & ~prev.
  - Edge, polarity=0: ~in & prev.
  - Level: in == polarity.
- Event is masked by irq_enable[i]. A disabled channel keeps its existing pending bit; that bit is excluded from arbitration.
- pending[i] next-state: set if event; else cleared if irq_clear[i] or (ack_fire and irq_id==i); else hold. A set in the same cycle as a clear wins, so no edge is lost.
- Level channels re-set pending every cycle while active, so clear/ack only takes effect once the input deasserts.
- Latency (sync feature off):
  - Input transition at cycle k is detected combinationally against prev, so pending is visible at k+1.
  - irq_valid/irq_id are visible at k+2 if idle.
- Arbiter, where ack_fire = irq_valid & irq_ack:
  - If irq_valid=0: load the lowest enabled pending index; irq_valid=1 if any exists.
  - If irq_valid=1 and no ack: irq_id is held stable even if a lower index becomes pending.
  - On ack_fire: irq_valid=0 for the next cycle (bubble), then re-arbitrate. A just-acked edge ID is never re-presented unless a new event occurred.
  - If the presented channel's pending drops via irq_clear or irq_enable deasserts while valid: irq_valid=0 the next cycle, no ack needed.
- irq_ack while irq_valid=0: ignored.
- irq_id is don't-care when irq_valid=0; it holds its last value.
- Reset asserted mid-handshake: all state returns to reset values the next cycle; outstanding IDs are discarded.

Optional Feature:
INTR_SYNC_EN: when defined, each irq_in bit passes through a 2-flop synchronizer (reset to 0) before prev and detection. Event latency increases by 2 cycles (pending at k+3, irq_valid at k+4). armed asserts 3 cycles after reset release so synchronizer contents settle. When undefined, irq_in feeds detection directly with the latency above.

Test Plan:
- Reset with irq_in=0xFFFFFFFF held high, all edge/rising/enabled, then release -> pending stays 0, irq_valid stays 0.
- irq_in[5] 0->1 at cycle k, edge/rising/enabled -> pending=0x20 at k+1; irq_valid=1, irq_id=5 at k+2; ack -> pending=0, irq_valid=0 next cycle.
- ch3 falling edge and ch7 rising edge in the same cycle -> irq_id=3 first; after ack and 1 bubble cycle, irq_id=7; after second ack, pending=0.
- ch2 level/high held high, ack ID 2 -> pending[2] stays 1 and ID 2 is re-presented after the bubble; drop input then ack -> pending[2]=0.
- ch9 edge event in the same cycle as irq_clear[9]=1 -> pending[9]=1 (set wins); ch9 presented, then irq_enable[9]=0 -> irq_valid=0 next cycle while pending[9] stays 1.
- INTR_SYNC_EN defined: irq_in[0] rises at k -> pending[0] at k+3, irq_valid at k+4, irq_id=0.
